// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode tags, default widths and the result-pipeline entry record.
// Define ALU_RESULT_SKID_PARITY_EN to carry an even-parity bit with every entry.
package alu_pkg;

   localparam int WIDTH = 32;
   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OPC_AND = 5'd0;
   localparam logic [OPC_W-1:0] OPC_OR  = 5'd1;
   localparam logic [OPC_W-1:0] OPC_ADD = 5'd2;
   localparam logic [OPC_W-1:0] OPC_SUB = 5'd3;
   localparam logic [OPC_W-1:0] OPC_SLL = 5'd4;
   localparam logic [OPC_W-1:0] OPC_SRL = 5'd5;
   localparam logic [OPC_W-1:0] OPC_SRA = 5'd6;
   localparam logic [OPC_W-1:0] OPC_XOR = 5'd7;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [OPC_W-1:0] opcode;
      logic             zero;
      logic             neg;
      logic             ovf;
`ifdef ALU_RESULT_SKID_PARITY_EN
      logic             parity;
`endif
   } aluEntry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skidState_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational flag derivation for an ALU result: zero, negative and,
// with ALU_RESULT_SKID_PARITY_EN defined, even parity.
module alu_flag_calc #(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg
`ifdef ALU_RESULT_SKID_PARITY_EN
   ,
   output logic             parity
`endif
);

   assign zero = (result == '0);
   assign neg  = result[WIDTH-1];

`ifdef ALU_RESULT_SKID_PARITY_EN
   assign parity = ^result;
`endif

endmodule

// File: rtl/alu_result_skid.sv
// Registered ALU result stage: 2-entry skid buffer with valid/ready on both sides and
// flags derived at capture. ALU_RESULT_SKID_PARITY_EN adds the out_parity port.
module alu_result_skid #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OPC_W = alu_pkg::OPC_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [OPC_W-1:0] in_opcode,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [OPC_W-1:0] out_opcode,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf
`ifdef ALU_RESULT_SKID_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   import alu_pkg::*;

   skidState_t state;
   skidState_t stateNext;
   logic       inReadyQ;
   logic       stateValid;
   logic       acceptBeat;
   logic       releaseBeat;
   logic       loadMainNew;
   logic       loadMainSkid;
   logic       loadSkid;
   aluEntry_t  newEntry;
   aluEntry_t  mainEntry;
   aluEntry_t  skidEntry;
   logic       inZero;
   logic       inNeg;
`ifdef ALU_RESULT_SKID_PARITY_EN
   logic       inParity;
`endif

   alu_flag_calc #(
      .WIDTH (WIDTH)
   ) uFlagCalc (
      .result (in_result),
      .zero   (inZero),
      .neg    (inNeg)
`ifdef ALU_RESULT_SKID_PARITY_EN
      ,
      .parity (inParity)
`endif
   );

   // Handshakes are masked while reset is low so no beat moves in the reset cycle.
   assign stateValid  = (state != EMPTY);
   assign out_valid   = stateValid & reset_n;
   assign in_ready    = inReadyQ & reset_n;
   assign acceptBeat  = in_valid & in_ready;
   assign releaseBeat = out_valid & out_ready;

   always_comb begin
      newEntry        = '0;
      newEntry.result = in_result;
      newEntry.opcode = in_opcode;
      newEntry.zero   = inZero;
      newEntry.neg    = inNeg;
      newEntry.ovf    = in_ovf;
`ifdef ALU_RESULT_SKID_PARITY_EN
      newEntry.parity = inParity;
`endif
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state    <= EMPTY;
         inReadyQ <= 1'b0;
      end else begin
         state    <= stateNext;
         inReadyQ <= (stateNext != TWO);
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         EMPTY: if (acceptBeat) stateNext = ONE;
         ONE: begin
            if (acceptBeat && !releaseBeat) stateNext = TWO;
            else if (!acceptBeat && releaseBeat) stateNext = EMPTY;
         end
         TWO: if (releaseBeat) stateNext = ONE;
         default: stateNext = EMPTY;
      endcase
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
      loadMainNew  = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      unique case (state)
         EMPTY: loadMainNew = acceptBeat;
         ONE: begin
            loadMainNew = acceptBeat & releaseBeat;
            loadSkid    = acceptBeat & ~releaseBeat;
         end
         TWO: loadMainSkid = releaseBeat;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mainEntry <= '0;
      end else if (loadMainNew) begin
         mainEntry <= newEntry;
      end else if (loadMainSkid) begin
         mainEntry <= skidEntry;
      end
   end

   // NOTE: skid data is not reset; it is only observable once the state marks it occupied.
   always_ff @(posedge clock) begin
      if (loadSkid) begin
         skidEntry <= newEntry;
      end
   end

   assign out_result = mainEntry.result;
   assign out_opcode = mainEntry.opcode;
   assign out_zero   = mainEntry.zero;
   assign out_neg    = mainEntry.neg;
   assign out_ovf    = mainEntry.ovf;
`ifdef ALU_RESULT_SKID_PARITY_EN
   assign out_parity = mainEntry.parity;
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// Self-checking bench for alu_result_skid: directed scenario tasks plus a FIFO scoreboard
// fed at every accept and drained at every release.
module tb_alu_result_skid;

   localparam int W  = 32;
   localparam int OW = 5;
   localparam logic [OW-1:0] OPC_OR  = 5'd1;
   localparam logic [OW-1:0] OPC_ADD = 5'd2;

   typedef struct packed {
      logic [W-1:0]  result;
      logic [OW-1:0] opcode;
      logic          zero;
      logic          neg;
      logic          ovf;
      logic          parity;
   } expBeat_t;

   logic          clock;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_result;
   logic [OW-1:0] in_opcode;
   logic          in_ovf;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic [OW-1:0] out_opcode;
   logic          out_zero;
   logic          out_neg;
   logic          out_ovf;
`ifdef ALU_RESULT_SKID_PARITY_EN
   logic          out_parity;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int pushCount   = 0;
   int popCount    = 0;
   expBeat_t sb[$];
   expBeat_t monExp;
   expBeat_t monObs;

   alu_result_skid dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_opcode  (in_opcode),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_opcode (out_opcode),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_ovf    (out_ovf)
`ifdef ALU_RESULT_SKID_PARITY_EN
      ,
      .out_parity (out_parity)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic expBeat_t model(input logic [W-1:0] r, input logic [OW-1:0] opc,
                                      input logic ovf);
      expBeat_t e;
      e.result = r;
      e.opcode = opc;
      e.zero   = (r == '0);
      e.neg    = r[W-1];
      e.ovf    = ovf;
      e.parity = ^r;
      return e;
   endfunction

   // Handshakes are evaluated mid-cycle; the transfer itself happens at the next rising edge.
   always @(negedge clock) begin
      if (!reset_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            testsRun++;
            if (sb.size() == 0) begin
               testsFailed++;
               $display("FAIL sb_underflow: got beat result=%h with nothing expected", out_result);
            end else begin
               monExp = sb.pop_front();
               popCount++;
               monObs.result = out_result;
               monObs.opcode = out_opcode;
               monObs.zero   = out_zero;
               monObs.neg    = out_neg;
               monObs.ovf    = out_ovf;
               monObs.parity = 1'b0;
`ifdef ALU_RESULT_SKID_PARITY_EN
               monObs.parity = out_parity;
`else
               monExp.parity = 1'b0;
`endif
               if (monObs !== monExp) begin
                  testsFailed++;
                  $display("FAIL sb_beat: got %h expected %h", monObs, monExp);
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(in_result, in_opcode, in_ovf));
            pushCount++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic sendBeat(input logic [W-1:0] r, input logic [OW-1:0] opc, input logic ovf);
      bit ok;
      in_valid  = 1'b1;
      in_result = r;
      in_opcode = opc;
      in_ovf    = ovf;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock);
         #1;
      end
      if (!ok) begin
         testsRun++;
         testsFailed++;
         $display("FAIL send_timeout: beat %h never accepted", r);
      end
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      in_result = 'x;
      in_opcode = 'x;
      in_ovf    = 1'bx;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         testsRun++;
         if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
         end
         testsRun++;
         if (in_ready !== 1'b0) begin
            testsFailed++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
         end
      end
      testsRun++;
      if ({out_result, out_opcode, out_zero, out_neg, out_ovf} !== '0) begin
         testsFailed++;
         $display("FAIL reset_data: got result=%h opc=%h z=%b n=%b o=%b expected all 0",
                  out_result, out_opcode, out_zero, out_neg, out_ovf);
      end
      reset_n  = 1'b1;
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      testsRun++;
      if (in_ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL release_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_streaming();
      logic [W-1:0] vals [3];
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = 32'h9;
      b = 32'h12;
      vals[0] = a | b;
      vals[1] = 32'h0;
      vals[2] = 32'h8000_0000;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sendBeat(vals[k], OPC_OR, 1'b0);
         testsRun++;
         if (out_valid !== 1'b1 || out_result !== vals[k]) begin
            testsFailed++;
            $display("FAIL stream_data%0d: got valid=%b result=%h expected valid=1 result=%h",
                     k, out_valid, out_result, vals[k]);
         end
         testsRun++;
         if (out_zero !== (k == 1) || out_neg !== (k == 2)) begin
            testsFailed++;
            $display("FAIL stream_flags%0d: got z=%b n=%b expected z=%b n=%b",
                     k, out_zero, out_neg, (k == 1), (k == 2));
         end
         testsRun++;
         if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("FAIL stream_in_ready%0d: got %b expected 1", k, in_ready);
         end
      end
      idle(1);
      testsRun++;
      if (out_valid !== 1'b0) begin
         testsFailed++;
         $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      sendBeat(32'h1B, OPC_OR, 1'b0);
      sendBeat(32'h2D, OPC_OR, 1'b0);
      idle(0);
      testsRun++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h1B) begin
         testsFailed++;
         $display("FAIL bp_full: got in_ready=%b valid=%b result=%h expected 0 1 0000001b",
                  in_ready, out_valid, out_result);
      end
      idle(2);
      testsRun++;
      if (out_result !== 32'h1B || out_valid !== 1'b1) begin
         testsFailed++;
         $display("FAIL bp_hold: got valid=%b result=%h expected 1 0000001b", out_valid, out_result);
      end
      out_ready = 1'b1;
      idle(1);
      testsRun++;
      if (out_result !== 32'h2D || out_valid !== 1'b1 || in_ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL bp_second: got valid=%b result=%h in_ready=%b expected 1 0000002d 1",
                  out_valid, out_result, in_ready);
      end
      idle(1);
      testsRun++;
      if (out_valid !== 1'b0) begin
         testsFailed++;
         $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_random_stream();
      int i;
      int j;
      bit drvDone;
      int pushStart;
      int popStart;
      i = 0;
      j = 0;
      drvDone = 1'b0;
      pushStart = pushCount;
      popStart  = popCount;
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               logic [W-1:0]  r;
               logic [OW-1:0] opc;
               logic          ovf;
               r = W'(i) | W'(j);
               j += 9;
               if (j > 297) begin
                  j = 0;
                  i += 9;
               end
               opc = ($urandom_range(0, 1) == 1) ? OPC_ADD : OPC_OR;
               ovf = (opc == OPC_ADD) ? 1'($urandom_range(0, 1)) : 1'b0;
               if ($urandom_range(0, 2) == 0) idle(1);
               sendBeat(r, opc, ovf);
            end
            idle(0);
            drvDone = 1'b1;
         end
         begin
            while (!drvDone) begin
               @(posedge clock);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      for (int c = 0; c < 100 && sb.size() != 0; c++) begin
         @(posedge clock);
         #1;
      end
      testsRun++;
      if (sb.size() != 0) begin
         testsFailed++;
         $display("FAIL rand_drain: got %0d beats outstanding expected 0", sb.size());
      end
      testsRun++;
      if ((pushCount - pushStart) != 1000 || (popCount - popStart) != 1000) begin
         testsFailed++;
         $display("FAIL rand_count: got pushed=%0d popped=%0d expected 1000 1000",
                  pushCount - pushStart, popCount - popStart);
      end
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      sendBeat(32'hA5, OPC_OR, 1'b0);
      sendBeat(32'h5A, OPC_ADD, 1'b1);
      idle(0);
      testsRun++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         testsFailed++;
         $display("FAIL mid_full: got in_ready=%b valid=%b expected 0 1", in_ready, out_valid);
      end
      reset_n = 1'b0;
      @(negedge clock);
      testsRun++;
      if (out_valid !== 1'b0) begin
         testsFailed++;
         $display("FAIL mid_reset_valid: got %b expected 0", out_valid);
      end
      @(posedge clock);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      testsRun++;
      if (out_result !== '0) begin
         testsFailed++;
         $display("FAIL mid_reset_data: got %h expected 0", out_result);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         testsRun++;
         if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("FAIL mid_stale%0d: got out_valid=%b expected 0", k, out_valid);
         end
      end
      @(posedge clock);
      #1;
   endtask

`ifdef ALU_RESULT_SKID_PARITY_EN
   task automatic test_parity();
      out_ready = 1'b1;
      sendBeat(32'h1B, OPC_OR, 1'b0);
      testsRun++;
      if (out_parity !== 1'b0) begin
         testsFailed++;
         $display("FAIL parity_1b: got %b expected 0", out_parity);
      end
      sendBeat(32'h7, OPC_OR, 1'b0);
      testsRun++;
      if (out_parity !== 1'b1) begin
         testsFailed++;
         $display("FAIL parity_07: got %b expected 1", out_parity);
      end
      idle(2);
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_result = 32'h55;
      in_opcode = OPC_OR;
      in_ovf    = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_random_stream();
      test_reset_midop();
`ifdef ALU_RESULT_SKID_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
